// File: rtl/seq_detector_param_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_detector_param_pkg
// Description : Shared constants and helpers for the serial pattern detector.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_detector_param_pkg;

    localparam int PAT_W_MIN = 2;
    localparam int PAT_W_MAX = 32;

    localparam logic [3:0] DEF_PATTERN = 4'b1001;

    // Bits needed to hold a fill level of 0..pat_w inclusive.
    function automatic int calc_fill_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_detector_param_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_detector_param_if
// Description : Data/control bundle between the bit-serial source and detector.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_detector_param_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    logic             I;
    logic             in_valid;
    logic             overlap;
    logic             load;
    logic [PAT_W-1:0] pattern_in;
    logic             O;
    logic [CNT_W-1:0] match_count;
    logic [PAT_W-1:0] pattern;

    modport master (
        output I, in_valid, overlap, load, pattern_in,
        input  O, match_count, pattern
    );

    modport slave (
        input  I, in_valid, overlap, load, pattern_in,
        output O, match_count, pattern
    );
endinterface
`default_nettype wire

// File: rtl/seq_detector_param_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : W-bit up counter with synchronous clear that holds at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 8
) (
    input  wire logic         clock,
    input  wire logic         reset,
    input  wire logic         clr,
    input  wire logic         inc,
    output logic      [W-1:0] q
);
    localparam logic [W-1:0] C_MAX = '1;

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            q <= '0;
        end else if (inc && (q != C_MAX)) begin
            q <= q + W'(1);
        end
    end
endmodule
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module      : seq_detector_param
// Description : Programmable PAT_W-bit serial pattern detector, Moore match flag
//               with optional overlap and a saturating match counter.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detector_param
    import seq_detector_param_pkg::*;
#(
    parameter int               PAT_W     = 4,
    parameter int               CNT_W     = 8,
    parameter logic [PAT_W-1:0] PAT_RESET = PAT_W'(DEF_PATTERN)
) (
    input  wire logic            clock,
    input  wire logic            reset,
    seq_detector_param_if.slave  bus
);
    localparam int               FILL_W = calc_fill_w(PAT_W);
    localparam logic [FILL_W-1:0] C_FULL = FILL_W'(PAT_W);

    if ((PAT_W < PAT_W_MIN) || (PAT_W > PAT_W_MAX)) begin : g_pat_w_check
        $error("seq_detector_param: PAT_W out of legal range 2..32");
    end

    // The oldest history bit is shifted out before it is ever compared,
    // so only PAT_W-1 bits need to be stored.
    logic [PAT_W-2:0]  r_hist;
    logic [FILL_W-1:0] r_fill;
    logic              r_matched;
    logic [PAT_W-1:0]  r_pattern;

    logic              w_accept;
    logic [PAT_W-1:0]  w_nh;
    logic [FILL_W-1:0] w_nf;
    logic              w_hit;

    always_comb begin
        w_accept = bus.in_valid && !bus.load;
        w_nh     = {r_hist, bus.I};
        w_nf     = (r_fill == C_FULL) ? C_FULL : (r_fill + FILL_W'(1));
        w_hit    = (w_nf == C_FULL) && (w_nh == r_pattern);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pattern <= PAT_RESET;
            r_hist    <= '0;
            r_fill    <= '0;
            r_matched <= 1'b0;
        end else if (bus.load) begin
            r_pattern <= bus.pattern_in;
            r_hist    <= '0;
            r_fill    <= '0;
            r_matched <= 1'b0;
        end else if (bus.in_valid) begin
            r_hist    <= w_nh[PAT_W-2:0];
            r_matched <= w_hit;
            // Non-overlapping mode forgets the matched run entirely.
            r_fill    <= (w_hit && !bus.overlap) ? '0 : w_nf;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (bus.load),
        .inc   (w_accept && w_hit),
        .q     (bus.match_count)
    );

    assign bus.O       = r_matched;
    assign bus.pattern = r_pattern;

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_detector_param
// Description : Self-checking bench: vector table, saturation sequence and a
//               randomized stream against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detector_param;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    seq_detector_param_if #(.PAT_W(4), .CNT_W(8)) ia ();
    seq_detector_param_if #(.PAT_W(2), .CNT_W(2)) is ();
    seq_detector_param_if #(.PAT_W(8), .CNT_W(8)) ir ();

    seq_detector_param #(.PAT_W(4), .CNT_W(8), .PAT_RESET(4'b1001)) dut_a (
        .clock (clock), .reset (reset), .bus (ia.slave));
    seq_detector_param #(.PAT_W(2), .CNT_W(2), .PAT_RESET(2'b11)) dut_s (
        .clock (clock), .reset (reset), .bus (is.slave));
    seq_detector_param #(.PAT_W(8), .CNT_W(8), .PAT_RESET(8'hA5)) dut_r (
        .clock (clock), .reset (reset), .bus (ir.slave));

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rst;
        logic       ld;
        logic [3:0] pin;
        logic       vld;
        logic       bit_i;
        logic       ov;
        logic       exp_o;
        logic [7:0] exp_cnt;
        logic [3:0] exp_pat;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic ld, input logic [3:0] pin,
                       input logic vld, input logic b, input logic ov,
                       input logic eo, input logic [7:0] ec, input logic [3:0] ep);
        vec_t v;
        v.rst = rst; v.ld = ld; v.pin = pin; v.vld = vld; v.bit_i = b; v.ov = ov;
        v.exp_o = eo; v.exp_cnt = ec; v.exp_pat = ep;
        tbl.push_back(v);
    endtask

    task automatic bitv(input logic b, input logic ov, input logic eo,
                        input logic [7:0] ec, input logic [3:0] ep);
        add(1'b0, 1'b0, 4'h0, 1'b1, b, ov, eo, ec, ep);
    endtask

    task automatic idle(input logic eo, input logic [7:0] ec, input logic [3:0] ep);
        add(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, eo, ec, ep);
    endtask

    // Reference model state for the 8-bit random run.
    bit         mq[$];
    logic [7:0] mpat;
    int         mcnt;
    logic       mo;

    initial begin
        ia.I = 0; ia.in_valid = 0; ia.overlap = 1; ia.load = 0; ia.pattern_in = '0;
        is.I = 0; is.in_valid = 0; is.overlap = 1; is.load = 0; is.pattern_in = '0;
        ir.I = 0; ir.in_valid = 0; ir.overlap = 1; ir.load = 0; ir.pattern_in = '0;

        // ---------------- vector table on the 4-bit detector ----------------
        add(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 4'b1001);
        bitv(1, 1, 0, 0, 4'h9); bitv(0, 1, 0, 0, 4'h9); bitv(0, 1, 0, 0, 4'h9);
        bitv(1, 1, 1, 1, 4'h9); bitv(0, 1, 0, 1, 4'h9); bitv(0, 1, 0, 1, 4'h9);
        bitv(1, 1, 1, 2, 4'h9);
        add(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'b1001);
        bitv(1, 0, 0, 0, 4'h9); bitv(0, 0, 0, 0, 4'h9); bitv(0, 0, 0, 0, 4'h9);
        bitv(1, 0, 1, 1, 4'h9); bitv(0, 0, 0, 1, 4'h9); bitv(0, 0, 0, 1, 4'h9);
        bitv(1, 0, 0, 1, 4'h9);
        // load 1111 with a bit presented in the same cycle
        add(1'b0, 1'b1, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 4'b1111);
        bitv(1, 1, 0, 0, 4'hF); bitv(1, 1, 0, 0, 4'hF); bitv(1, 1, 0, 0, 4'hF);
        bitv(1, 1, 1, 1, 4'hF); bitv(1, 1, 1, 2, 4'hF); bitv(1, 1, 1, 3, 4'hF);
        // back to 1001, then bits separated by idle gaps
        add(1'b0, 1'b1, 4'b1001, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 4'b1001);
        bitv(1, 1, 0, 0, 4'h9); idle(0, 0, 4'h9); idle(0, 0, 4'h9); idle(0, 0, 4'h9);
        bitv(0, 1, 0, 0, 4'h9); idle(0, 0, 4'h9); idle(0, 0, 4'h9); idle(0, 0, 4'h9);
        bitv(0, 1, 0, 0, 4'h9); idle(0, 0, 4'h9); idle(0, 0, 4'h9); idle(0, 0, 4'h9);
        bitv(1, 1, 1, 1, 4'h9); idle(1, 1, 4'h9); idle(1, 1, 4'h9); idle(1, 1, 4'h9);
        // load with in_valid: the '1' must be dropped, so 0,0,1 cannot complete 1001
        add(1'b0, 1'b1, 4'b1001, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 4'b1001);
        bitv(0, 1, 0, 0, 4'h9); bitv(0, 1, 0, 0, 4'h9); bitv(1, 1, 0, 0, 4'h9);
        // reset mid-stream discards partial history
        add(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 4'b1001);
        bitv(1, 1, 0, 0, 4'h9); bitv(0, 1, 0, 0, 4'h9); bitv(0, 1, 0, 0, 4'h9);
        add(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 4'b1001);
        bitv(1, 1, 0, 0, 4'h9);

        foreach (tbl[k]) begin
            reset         = tbl[k].rst;
            ia.load       = tbl[k].ld;
            ia.pattern_in = tbl[k].pin;
            ia.in_valid   = tbl[k].vld;
            ia.I          = tbl[k].bit_i;
            ia.overlap    = tbl[k].ov;
            @(posedge clock); #1;
            check($sformatf("vec%0d O", k), 32'(ia.O), 32'(tbl[k].exp_o));
            check($sformatf("vec%0d count", k), 32'(ia.match_count), 32'(tbl[k].exp_cnt));
            check($sformatf("vec%0d pattern", k), 32'(ia.pattern), 32'(tbl[k].exp_pat));
        end
        reset = 0; ia.in_valid = 0; ia.load = 0;

        // ---------------- saturation: PAT_W=2, CNT_W=2, pattern 11 ----------------
        reset = 1;
        @(posedge clock); #1;
        reset = 0;
        check("sat reset pattern", 32'(is.pattern), 32'h3);
        check("sat reset count", 32'(is.match_count), 32'd0);
        for (int n = 1; n <= 6; n++) begin
            is.in_valid = 1; is.I = 1; is.overlap = 1;
            @(posedge clock); #1;
            check($sformatf("sat bit%0d O", n), 32'(is.O), (n >= 2) ? 32'd1 : 32'd0);
            check($sformatf("sat bit%0d count", n), 32'(is.match_count),
                  32'((n - 1 > 3) ? 3 : n - 1));
        end
        is.in_valid = 0;

        // ---------------- random stream vs. reference model ----------------
        reset = 1;
        @(posedge clock); #1;
        reset = 0;
        mq.delete(); mpat = 8'hA5; mcnt = 0; mo = 0;
        check("rnd reset pattern", 32'(ir.pattern), 32'hA5);
        begin
            int plant = 0;
            for (int c = 0; c < 3000; c++) begin
                logic r, l, v, b, ov;
                logic [7:0] pin;
                r   = ($urandom_range(0, 299) == 0);
                l   = ($urandom_range(0, 99) == 0);
                pin = ($urandom_range(0, 1) == 1) ? 8'hA5 : 8'($urandom);
                v   = ($urandom_range(0, 3) != 0);
                ov  = 1'($urandom_range(0, 1));
                b   = 1'($urandom_range(0, 1));
                if (plant == 0 && $urandom_range(0, 11) == 0) plant = 8;
                if (plant > 0 && v) begin
                    b = mpat[plant-1];
                    plant--;
                end
                reset = r; ir.load = l; ir.pattern_in = pin;
                ir.in_valid = v; ir.I = b; ir.overlap = ov;
                // reference model: last PAT_W accepted bits since clear point
                if (r) begin
                    mq.delete(); mpat = 8'hA5; mcnt = 0; mo = 0;
                end else if (l) begin
                    mq.delete(); mpat = pin; mcnt = 0; mo = 0;
                end else if (v) begin
                    logic [7:0] win;
                    logic       hit;
                    mq.push_back(b);
                    if (mq.size() > 8) void'(mq.pop_front());
                    win = '0;
                    foreach (mq[i]) win = {win[6:0], 1'(mq[i])};
                    hit = (mq.size() == 8) && (win == mpat);
                    mo = hit;
                    if (hit) begin
                        if (mcnt < 255) mcnt++;
                        if (!ov) mq.delete();
                    end
                end
                @(posedge clock); #1;
                check($sformatf("rnd%0d O", c), 32'(ir.O), 32'(mo));
                check($sformatf("rnd%0d count", c), 32'(ir.match_count), 32'(mcnt));
                check($sformatf("rnd%0d pattern", c), 32'(ir.pattern), 32'(mpat));
            end
        end
        reset = 0; ir.in_valid = 0; ir.load = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
